// File: rtl/warp_barrier_ctrl.sv
// Per-core local barrier controller: collects warp arrivals per barrier slot,
// stalls waiters and releases the whole group with one unlock pulse.
module warp_barrier_ctrl #(
   parameter int NUM_WARPS    = 4,
   parameter int NUM_BARRIERS = 4,
   parameter int PERF_W       = 44,
   localparam int NW_W = $clog2(NUM_WARPS),
   localparam int NB_W = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [NW_W-1:0]      req_wid,
   input  logic [NB_W-1:0]      req_id,
   input  logic [NW_W-1:0]      req_size_m1,
   input  logic                 req_is_noop,
   output logic [NUM_WARPS-1:0] stall_mask,
   output logic                 unlock_valid,
   output logic [NUM_WARPS-1:0] unlock_wmask,
   output logic                 err_valid,
   output logic [PERF_W-1:0]    perf_stalls
);

   typedef enum logic [1:0] {
      ST_RESET   = 2'd0,
      ST_IDLE    = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [NUM_BARRIERS-1:0][NUM_WARPS-1:0] wait_q, wait_d;
   logic [NUM_BARRIERS-1:0][NW_W-1:0]      count_q, count_d;
   logic [NUM_BARRIERS-1:0][NW_W-1:0]      size_q, size_d;
   logic [NUM_BARRIERS-1:0]                active_q, active_d;

   logic                 unlock_valid_q, unlock_valid_d;
   logic [NUM_WARPS-1:0] unlock_wmask_q, unlock_wmask_d;
   logic                 err_q, err_d;
   logic [PERF_W-1:0]    perf_q, perf_d;

   logic [NUM_WARPS-1:0] stall_all;
   logic [NW_W:0]        stall_cnt;
   logic [NUM_WARPS-1:0] req_onehot;
   logic                 req_err;
   logic                 req_complete;

   // Stall view is the union of every slot's waiters.
   always_comb begin
      stall_all = '0;
      for (int b = 0; b < NUM_BARRIERS; b++) begin
         stall_all = stall_all | wait_q[b];
      end
   end

   always_comb begin
      stall_cnt = '0;
      for (int i = 0; i < NUM_WARPS; i++) begin
         stall_cnt = stall_cnt + {{NW_W{1'b0}}, stall_all[i]};
      end
   end

   assign req_onehot   = NUM_WARPS'(1) << req_wid;
   assign req_err      = stall_all[req_wid] ||
                         (active_q[req_id] && (req_size_m1 != size_q[req_id]));
   assign req_complete = active_q[req_id] ? (count_q[req_id] == size_q[req_id])
                                          : (req_size_m1 == '0);

   always_comb begin
      state_d        = state_q;
      wait_d         = wait_q;
      count_d        = count_q;
      size_d         = size_q;
      active_d       = active_q;
      unlock_valid_d = 1'b0;
      unlock_wmask_d = '0;
      err_d          = 1'b0;
      perf_d         = perf_q + PERF_W'(stall_cnt);

      case (state_q)
         ST_RESET:   state_d = ST_IDLE;
         ST_RELEASE: state_d = ST_IDLE;
         ST_IDLE: begin
            if (req_valid) begin
               if (req_is_noop) begin
                  unlock_valid_d = 1'b1;
                  unlock_wmask_d = req_onehot;
               end else if (req_err) begin
                  err_d = 1'b1;
               end else if (req_complete) begin
                  // Arriving warp is released directly and never marked as waiting.
                  unlock_valid_d   = 1'b1;
                  unlock_wmask_d   = wait_q[req_id] | req_onehot;
                  wait_d[req_id]   = '0;
                  count_d[req_id]  = '0;
                  size_d[req_id]   = '0;
                  active_d[req_id] = 1'b0;
                  state_d          = ST_RELEASE;
               end else begin
                  if (!active_q[req_id]) begin
                     active_d[req_id] = 1'b1;
                     size_d[req_id]   = req_size_m1;
                     count_d[req_id]  = NW_W'(1);
                  end else begin
                     count_d[req_id] = count_q[req_id] + NW_W'(1);
                  end
                  wait_d[req_id] = wait_q[req_id] | req_onehot;
               end
            end
         end
         default: state_d = ST_RESET;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= ST_RESET;
         wait_q         <= '0;
         count_q        <= '0;
         size_q         <= '0;
         active_q       <= '0;
         unlock_valid_q <= 1'b0;
         unlock_wmask_q <= '0;
         err_q          <= 1'b0;
         perf_q         <= '0;
      end else begin
         state_q        <= state_d;
         wait_q         <= wait_d;
         count_q        <= count_d;
         size_q         <= size_d;
         active_q       <= active_d;
         unlock_valid_q <= unlock_valid_d;
         unlock_wmask_q <= unlock_wmask_d;
         err_q          <= err_d;
         perf_q         <= perf_d;
      end
   end

   assign req_ready    = (state_q == ST_IDLE);
   assign stall_mask   = stall_all;
   assign unlock_valid = unlock_valid_q;
   assign unlock_wmask = unlock_wmask_q;
   assign err_valid    = err_q;
   assign perf_stalls  = perf_q;

endmodule

// File: tb/tb_warp_barrier_ctrl.sv
// Directed bench for warp_barrier_ctrl with 4 warps / 4 barrier slots.
module tb_warp_barrier_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_wid;
   logic [1:0]  req_id;
   logic [1:0]  req_size_m1;
   logic        req_is_noop;
   logic [3:0]  stall_mask;
   logic        unlock_valid;
   logic [3:0]  unlock_wmask;
   logic        err_valid;
   logic [43:0] perf_stalls;

   int passes = 0;
   int total  = 0;
   logic [43:0] perf_base;

   warp_barrier_ctrl #(.NUM_WARPS(4), .NUM_BARRIERS(4), .PERF_W(44)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_wid      (req_wid),
      .req_id       (req_id),
      .req_size_m1  (req_size_m1),
      .req_is_noop  (req_is_noop),
      .stall_mask   (stall_mask),
      .unlock_valid (unlock_valid),
      .unlock_wmask (unlock_wmask),
      .err_valid    (err_valid),
      .perf_stalls  (perf_stalls)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one arrival for a single cycle; outputs are observed right after the accepting edge.
   task automatic arrive(input logic [1:0] w, input logic [1:0] id, input logic [1:0] sm,
                         input logic noop);
      chk("ready_before_arrival", {63'd0, req_ready}, 64'd1);
      req_valid   = 1'b1;
      req_wid     = w;
      req_id      = id;
      req_size_m1 = sm;
      req_is_noop = noop;
      tick();
      req_valid   = 1'b0;
      req_is_noop = 1'b0;
      $display("arrival w%0d id%0d sm%0d noop%0d -> stall=%b unlock=%b/%b err=%b ready=%b",
               w, id, sm, noop, stall_mask, unlock_valid, unlock_wmask, err_valid, req_ready);
   endtask

   initial begin
      reset_n     = 1'b0;
      req_valid   = 1'b1;
      req_wid     = 2'd1;
      req_id      = 2'd0;
      req_size_m1 = 2'd0;
      req_is_noop = 1'b0;

      // Reset held with a pending request.
      repeat (3) tick();
      chk("rst_ready",  {63'd0, req_ready},    64'd0);
      chk("rst_stall",  {60'd0, stall_mask},   64'd0);
      chk("rst_unlock", {63'd0, unlock_valid}, 64'd0);
      chk("rst_err",    {63'd0, err_valid},    64'd0);
      chk("rst_perf",   {20'd0, perf_stalls},  64'd0);
      req_valid = 1'b0;
      reset_n   = 1'b1;
      #1;
      chk("ready_low_until_edge", {63'd0, req_ready}, 64'd0);
      tick();
      chk("ready_after_edge", {63'd0, req_ready}, 64'd1);

      // Four-warp barrier on slot 2.
      arrive(2'd0, 2'd2, 2'd3, 1'b0);
      chk("b2_stall_w0", {60'd0, stall_mask}, 64'h1);
      arrive(2'd1, 2'd2, 2'd3, 1'b0);
      arrive(2'd2, 2'd2, 2'd3, 1'b0);
      chk("b2_stall_0111", {60'd0, stall_mask},   64'h7);
      chk("b2_no_unlock",  {63'd0, unlock_valid}, 64'd0);
      arrive(2'd3, 2'd2, 2'd3, 1'b0);
      chk("b2_unlock_v",   {63'd0, unlock_valid}, 64'd1);
      chk("b2_unlock_m",   {60'd0, unlock_wmask}, 64'hF);
      chk("b2_stall_clr",  {60'd0, stall_mask},   64'd0);
      chk("b2_ready_low",  {63'd0, req_ready},    64'd0);
      tick();
      chk("b2_ready_back", {63'd0, req_ready},    64'd1);
      chk("b2_unlock_one", {63'd0, unlock_valid}, 64'd0);

      // Interleaved barriers on slots 0 and 1.
      arrive(2'd0, 2'd0, 2'd1, 1'b0);
      arrive(2'd1, 2'd1, 2'd1, 1'b0);
      chk("il_stall_0011", {60'd0, stall_mask}, 64'h3);
      arrive(2'd2, 2'd0, 2'd1, 1'b0);
      chk("il_unlock0_v", {63'd0, unlock_valid}, 64'd1);
      chk("il_unlock0_m", {60'd0, unlock_wmask}, 64'h5);
      chk("il_stall_0010", {60'd0, stall_mask},  64'h2);
      tick();
      arrive(2'd3, 2'd1, 2'd1, 1'b0);
      chk("il_unlock1_v", {63'd0, unlock_valid}, 64'd1);
      chk("il_unlock1_m", {60'd0, unlock_wmask}, 64'hA);
      chk("il_stall_0",   {60'd0, stall_mask},   64'd0);
      tick();

      // Single-warp barrier and noop.
      arrive(2'd1, 2'd3, 2'd0, 1'b0);
      chk("sz0_unlock_v", {63'd0, unlock_valid}, 64'd1);
      chk("sz0_unlock_m", {60'd0, unlock_wmask}, 64'h2);
      chk("sz0_stall",    {60'd0, stall_mask},   64'd0);
      tick();
      arrive(2'd3, 2'd0, 2'd0, 1'b1);
      chk("noop_unlock_v", {63'd0, unlock_valid}, 64'd1);
      chk("noop_unlock_m", {60'd0, unlock_wmask}, 64'h8);
      chk("noop_stall",    {60'd0, stall_mask},   64'd0);
      chk("noop_ready",    {63'd0, req_ready},    64'd1);
      tick();

      // Protocol errors against slot 1 (size_lat = 2).
      arrive(2'd0, 2'd1, 2'd2, 1'b0);
      chk("err_setup_stall", {60'd0, stall_mask}, 64'h1);
      arrive(2'd0, 2'd1, 2'd2, 1'b0);
      chk("err_dup_pulse",  {63'd0, err_valid},    64'd1);
      chk("err_dup_stall",  {60'd0, stall_mask},   64'h1);
      chk("err_dup_unlock", {63'd0, unlock_valid}, 64'd0);
      arrive(2'd1, 2'd1, 2'd3, 1'b0);
      chk("err_size_pulse", {63'd0, err_valid},  64'd1);
      chk("err_size_stall", {60'd0, stall_mask}, 64'h1);
      tick();
      chk("err_pulse_end",  {63'd0, err_valid},  64'd0);
      arrive(2'd1, 2'd1, 2'd2, 1'b0);
      chk("err_cnt_stall",  {60'd0, stall_mask},   64'h3);
      chk("err_cnt_nounl",  {63'd0, unlock_valid}, 64'd0);
      arrive(2'd2, 2'd1, 2'd2, 1'b0);
      chk("err_cnt_unlock", {63'd0, unlock_valid}, 64'd1);
      chk("err_cnt_mask",   {60'd0, unlock_wmask}, 64'h7);
      tick();

      // Stall-cycle accounting, then reset mid-barrier.
      arrive(2'd0, 2'd3, 2'd2, 1'b0);
      arrive(2'd1, 2'd3, 2'd2, 1'b0);
      chk("perf_stall_0011", {60'd0, stall_mask}, 64'h3);
      perf_base = perf_stalls;
      repeat (10) tick();
      chk("perf_plus20", {20'd0, perf_stalls}, {20'd0, perf_base + 44'd20});
      reset_n = 1'b0;
      #1;
      chk("midrst_stall",  {60'd0, stall_mask},   64'd0);
      chk("midrst_ready",  {63'd0, req_ready},    64'd0);
      chk("midrst_perf",   {20'd0, perf_stalls},  64'd0);
      chk("midrst_unlock", {63'd0, unlock_valid}, 64'd0);
      tick();
      reset_n = 1'b1;
      tick();
      chk("postrst_ready",  {63'd0, req_ready},    64'd1);
      tick();
      chk("postrst_unlock", {63'd0, unlock_valid}, 64'd0);
      chk("postrst_stall",  {60'd0, stall_mask},   64'd0);
      chk("postrst_perf",   {20'd0, perf_stalls},  64'd0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule

// File: doc/warp_barrier_ctrl.md
Name: warp_barrier_ctrl

Overview:
Per-core local barrier controller. It accepts barrier arrivals from the issue/SFU path, one per cycle, each carrying warp id, barrier id, size_m1 and is_noop. It tracks the waiting warps per barrier and stalls them. When a barrier's arrival count is reached, it releases all of that barrier's waiters with a single unlock pulse to the warp scheduler. Global barriers are handled outside this block and never reach it.

Parameters:
NUM_WARPS, 4, warps per core; power of 2, ≥2; NW_W = clog2(NUM_WARPS)
NUM_BARRIERS, 4, local barrier slots; power of 2; NB_W = clog2(NUM_BARRIERS)
PERF_W, 44, stall-cycle counter width

Ports:
clk  in  1  clock; all state updates on rising edge
reset_n  in  1  asynchronous, active-low reset
req_valid  in  1  barrier arrival valid
req_ready  out  1  arrival accepted when req_valid && req_ready
req_wid  in  NW_W  arriving warp
req_id  in  NB_W  barrier id
req_size_m1  in  NW_W  participating warps minus 1
req_is_noop  in  1  arrival carries no synchronisation
stall_mask  out  NUM_WARPS  warps currently blocked at any barrier
unlock_valid  out  1  one-cycle release pulse
unlock_wmask  out  NUM_WARPS  warps released this pulse
err_valid  out  1  one-cycle protocol-error pulse
perf_stalls  out  PERF_W  accumulated sum of popcount(stall_mask) per cycle

Behaviour:
- Reset (async assert, sync deassert by the environment) clears all state. Values held in reset: req_ready=0, stall_mask=0, unlock_valid=0, unlock_wmask=0, err_valid=0, perf_stalls=0. req_ready rises on the first clk edge after reset_n deasserts.
- Per-barrier state: wait_mask[NUM_WARPS], count[NW_W], size_lat[NW_W], active bit.
- FSM: RESET -> IDLE (first edge after deassert). IDLE -> RELEASE when an accepted arrival completes a barrier. RELEASE -> IDLE unconditionally after 1 cycle.
- req_ready = 1 in IDLE and 0 in RELEASE. At most one arrival per two cycles can complete a barrier.
- Accepted arrival, non-noop, barrier b, warp w:
  - If b is inactive: latch size_lat = req_size_m1, count = 0, set active.
  - If size_m1 == 0 on first arrival: immediate completion.
  - Otherwise (not completing): set wait_mask[w], stall_mask[w] rises the next cycle, count += 1.
  - Completion when count == size_lat (pre-increment, active barrier) or size_m1 == 0. Next cycle: unlock_valid = 1 and unlock_wmask = wait_mask | (1<<w). Clear the barrier state and its warps' stall bits in that same update. The arriving warp is never shown as stalled.
- req_is_noop=1: accepted and no state change. Next cycle: unlock_valid = 1 with unlock_wmask = 1<<w; FSM stays in IDLE.
- Errors: err_valid pulses the cycle after acceptance. The arrival is otherwise ignored (no state change, no unlock).
  - Warp w already set in stall_mask (any barrier).
  - Active barrier and req_size_m1 != size_lat.
- Latency: arrival to unlock_valid is exactly 1 cycle. unlock_valid is never asserted two consecutive cycles by the same completion.
- Independent barriers accumulate concurrently. Count width wrap is impossible because count ≤ size_lat ≤ NUM_WARPS-1.
- perf_stalls wraps modulo 2^PERF_W.
- reset_n asserted mid-barrier: all waiters are dropped, and no unlock is emitted for them.

Test Plan:
- Reset: hold reset_n=0 with req_valid=1 -> req_ready=0, stall_mask=0, no unlock; first edge after release -> req_ready=1.
- 4-warp barrier id 2, size_m1=3, arrivals w0,w1,w2 in consecutive cycles -> stall_mask=0b0111. w3 arrives at T -> at T+1 unlock_valid=1, unlock_wmask=0b1111, stall_mask=0; req_ready=0 at T+1, 1 at T+2.
- Interleaved barriers: id0 size_m1=1 (w0,w2) and id1 size_m1=1 (w1,w3), arrival order w0,w1,w2,w3 -> unlock 0b0101 the cycle after w2; w3 is presented when req_ready returns -> unlock 0b1010.
- size_m1=0 arrival from w1, and separately is_noop from w3 -> each gives unlock_wmask=0b0010 / 0b1000 next cycle; stall_mask stays 0.
- Errors: w0 waiting on id1, w0 arrives again -> err_valid pulse, stall_mask unchanged. id1 size_lat=2, arrival with size_m1=3 -> err_valid, count unchanged.
- perf: w0,w1 stalled for 10 cycles -> perf_stalls increments by 2 per cycle (+20 total). Assert reset_n mid-wait -> all outputs 0 immediately, no unlock after release.
